// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

   localparam int          PC_W     = 32;
   localparam logic [31:0] NOP_WORD = 32'hE1A0_0000;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STALL = 2'd2,
      ST_FLUSH = 2'd3
   } fetch_state_e;

   function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
      return addr & ~32'h3;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bundle: pipeline control, instruction memory port and decode-facing outputs.
interface fetch_unit_if;
   import fetch_unit_pkg::*;

   logic            stall_i;
   logic            branch_i;
   logic [PC_W-1:0] branch_target_i;
   logic [PC_W-1:0] imem_addr_o;
   logic [31:0]     imem_rd_i;
   logic [31:0]     instr_o;
   logic [PC_W-1:0] pc_o;
   logic [PC_W-1:0] pc_plus8_o;
   logic            valid_o;
   logic            fault_o;

   modport master (
      input  stall_i, branch_i, branch_target_i, imem_rd_i,
      output imem_addr_o, instr_o, pc_o, pc_plus8_o, valid_o, fault_o
   );

   modport slave (
      output stall_i, branch_i, branch_target_i, imem_rd_i,
      input  imem_addr_o, instr_o, pc_o, pc_plus8_o, valid_o, fault_o
   );

endinterface

// File: rtl/fetch_ir_reg.sv
// Instruction register slot handed to decode; bubble wins over load, otherwise the slot holds.
module fetch_ir_reg #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD = fetch_unit_pkg::NOP_WORD
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        bubble,
   input  logic [31:0] instr_d,
   input  logic [31:0] pc_d,
   input  logic        fault_d,
   output logic [31:0] instr_q,
   output logic [31:0] pc_q,
   output logic        valid_q,
   output logic        fault_q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q <= NOP_WORD;
         pc_q    <= RESET_PC;
         valid_q <= 1'b0;
         fault_q <= 1'b0;
      end else if (bubble) begin
         // pc_q keeps its last value; it is meaningless while valid_q is low
         instr_q <= NOP_WORD;
         valid_q <= 1'b0;
         fault_q <= 1'b0;
      end else if (load) begin
         instr_q <= instr_d;
         pc_q    <= pc_d;
         valid_q <= 1'b1;
         fault_q <= fault_d;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing FSM with stall hold, branch redirect bubble and
// out-of-range fault slots.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_BOOT  | first edge after reset; nothing fetched, branches ignored
//   ST_RUN   | fetching one word per edge
//   ST_STALL | decode busy; PC and instruction slot frozen
//   ST_FLUSH | bubble issued after a redirect; fetch resumes at new PC
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IMEM_WORDS = 64,
   parameter logic [31:0] NOP_WORD   = fetch_unit_pkg::NOP_WORD
) (
   input  logic         clk,
   input  logic         rst_n,
   fetch_unit_if.master bus
);
   import fetch_unit_pkg::*;

   localparam logic [PC_W-1:0] IMEM_BYTES = IMEM_WORDS * 4;

   fetch_state_e    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            ir_load, ir_bubble;
   logic            in_range;
   logic [31:0]     fetch_word;

   assign in_range        = (pc_q < IMEM_BYTES);
   assign fetch_word      = in_range ? bus.imem_rd_i : NOP_WORD;
   assign bus.imem_addr_o = pc_q;
   assign bus.pc_plus8_o  = bus.pc_o + 32'd8;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // RUN, STALL and FLUSH share one rule set; only BOOT differs.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_load   = 1'b0;
      ir_bubble = 1'b0;
      case (state_q)
         ST_BOOT: state_d = ST_RUN;
         default: begin
            if (bus.branch_i) begin
               pc_d      = word_align(bus.branch_target_i);
               ir_bubble = 1'b1;
               state_d   = ST_FLUSH;
            end else if (bus.stall_i) begin
               state_d = ST_STALL;
            end else begin
               pc_d    = pc_q + 32'd4;
               ir_load = 1'b1;
               state_d = ST_RUN;
            end
         end
      endcase
   end

   fetch_ir_reg #(
      .RESET_PC (RESET_PC),
      .NOP_WORD (NOP_WORD)
   ) u_ir (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (ir_load),
      .bubble  (ir_bubble),
      .instr_d (fetch_word),
      .pc_d    (pc_q),
      .fault_d (~in_range),
      .instr_q (bus.instr_o),
      .pc_q    (bus.pc_o),
      .valid_q (bus.valid_o),
      .fault_q (bus.fault_o)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random stall/branch traffic
// against a behavioural fetch model.
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC   = 32'h0000_0000;
   localparam int          IMEM_WORDS = 64;
   localparam logic [31:0] NOP        = 32'hE1A0_0000;

   logic clk;
   logic rst_n;
   fetch_unit_if bus ();

   fetch_unit #(
      .RESET_PC   (RESET_PC),
      .IMEM_WORDS (IMEM_WORDS),
      .NOP_WORD   (NOP)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [31:0] mem [0:IMEM_WORDS-1];

   assign bus.imem_rd_i = (bus.imem_addr_o < IMEM_WORDS * 4) ?
                          mem[bus.imem_addr_o[7:2]] : 32'hDEAD_BEEF;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // model: next fetch address, expected slot contents, boot flag
   logic [31:0] m_pc, m_instr, m_pco;
   logic        m_valid, m_fault, m_booted;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task model_reset();
      m_pc     = RESET_PC;
      m_instr  = NOP;
      m_pco    = RESET_PC;
      m_valid  = 1'b0;
      m_fault  = 1'b0;
      m_booted = 1'b0;
   endtask

   task model_edge(input logic s, input logic b, input logic [31:0] t);
      if (!m_booted) begin
         m_booted = 1'b1;
      end else if (b) begin
         m_pc    = {t[31:2], 2'b00};
         m_instr = NOP;
         m_valid = 1'b0;
         m_fault = 1'b0;
      end else if (!s) begin
         m_pco   = m_pc;
         m_valid = 1'b1;
         if (m_pc / 4 < IMEM_WORDS) begin
            m_instr = mem[m_pc / 4];
            m_fault = 1'b0;
         end else begin
            m_instr = NOP;
            m_fault = 1'b1;
         end
         m_pc = m_pc + 4;
      end
   endtask

   task check_all();
      chk("imem_addr", bus.imem_addr_o, m_pc);
      chk("instr", bus.instr_o, m_instr);
      chk("valid", {31'b0, bus.valid_o}, {31'b0, m_valid});
      chk("fault", {31'b0, bus.fault_o}, {31'b0, m_fault});
      if (m_valid) begin
         chk("pc", bus.pc_o, m_pco);
         chk("pc_plus8", bus.pc_plus8_o, m_pco + 32'd8);
      end
   endtask

   task check_reset_values(input string tag);
      chk({tag, "_addr"},  bus.imem_addr_o, RESET_PC);
      chk({tag, "_instr"}, bus.instr_o, NOP);
      chk({tag, "_pc"},    bus.pc_o, RESET_PC);
      chk({tag, "_valid"}, {31'b0, bus.valid_o}, 32'd0);
      chk({tag, "_fault"}, {31'b0, bus.fault_o}, 32'd0);
   endtask

   task step(input logic s, input logic b, input logic [31:0] t);
      bus.stall_i         = s;
      bus.branch_i        = b;
      bus.branch_target_i = t;
      @(posedge clk);
      model_edge(s, b, t);
      #1;
      check_all();
   endtask

   logic [31:0] boot_words [0:3];

   initial begin
      boot_words[0] = 32'hE280_1000;
      boot_words[1] = 32'hE280_2000;
      boot_words[2] = 32'hE280_4000;
      boot_words[3] = 32'hE280_7000;
      for (int i = 0; i < IMEM_WORDS; i++) mem[i] = $urandom;
      for (int i = 0; i < 4; i++) mem[i] = boot_words[i];

      rst_n               = 1'b0;
      bus.stall_i         = 1'b0;
      bus.branch_i        = 1'b0;
      bus.branch_target_i = 32'h0;
      model_reset();
      #12;
      check_reset_values("rst");
      rst_n = 1'b1;

      // boot edge, then words 0..3 on edges 2..5
      step(1'b0, 1'b0, 32'h0);
      chk("boot_valid", {31'b0, bus.valid_o}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'b0, 32'h0);
         chk("seq_instr", bus.instr_o, boot_words[k]);
         chk("seq_pc", bus.pc_o, 32'(k * 4));
         chk("seq_valid", {31'b0, bus.valid_o}, 32'd1);
         if (k == 1) begin
            // pc_q is 8 here: stall three cycles
            for (int j = 0; j < 3; j++) begin
               step(1'b1, 1'b0, 32'h0);
               chk("stall_instr", bus.instr_o, 32'hE280_2000);
               chk("stall_pc", bus.pc_o, 32'h4);
            end
         end
      end

      // pc_q = 0x10: redirect to 0x2B
      chk("pre_branch_addr", bus.imem_addr_o, 32'h10);
      step(1'b0, 1'b1, 32'h0000_002B);
      chk("bubble_valid", {31'b0, bus.valid_o}, 32'd0);
      chk("bubble_instr", bus.instr_o, NOP);
      step(1'b0, 1'b0, 32'h0);
      chk("redirect_pc", bus.pc_o, 32'h28);

      // branch and stall together: branch wins
      step(1'b1, 1'b1, 32'h0000_0040);
      chk("brstall_valid", {31'b0, bus.valid_o}, 32'd0);
      step(1'b0, 1'b0, 32'h0);
      chk("brstall_pc", bus.pc_o, 32'h40);

      // run off the end of memory
      step(1'b0, 1'b1, 32'h0000_00F8);
      for (int j = 0; j < 3; j++) step(1'b0, 1'b0, 32'h0);
      chk("oob_pc", bus.pc_o, 32'h100);
      chk("oob_instr", bus.instr_o, NOP);
      chk("oob_fault", {31'b0, bus.fault_o}, 32'd1);
      chk("oob_valid", {31'b0, bus.valid_o}, 32'd1);

      // PC wrap at 2^32
      step(1'b0, 1'b1, 32'hFFFF_FFFF);
      step(1'b0, 1'b0, 32'h0);
      chk("wrap_pc", bus.pc_o, 32'hFFFF_FFFC);
      chk("wrap_plus8", bus.pc_plus8_o, 32'h4);
      chk("wrap_addr", bus.imem_addr_o, 32'h0);
      step(1'b0, 1'b0, 32'h0);
      chk("wrap_instr", bus.instr_o, boot_words[0]);

      // asynchronous reset mid-stall
      step(1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h0);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values("async_rst");
      model_reset();

      // branch during boot is ignored
      rst_n = 1'b1;
      step(1'b0, 1'b1, 32'h0000_0080);
      step(1'b0, 1'b0, 32'h0);
      chk("boot_branch_pc", bus.pc_o, RESET_PC);
      chk("boot_branch_instr", bus.instr_o, boot_words[0]);

      // random traffic
      for (int c = 0; c < 400; c++) begin
         logic        s, b;
         logic [31:0] t;
         s = ($urandom_range(99) < 30);
         b = ($urandom_range(99) < 10);
         t = ($urandom_range(9) == 0) ? $urandom : 32'($urandom_range(32'h13F));
         step(s, b, t);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
